// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I pipeline constants and the fetch-pair record.
//   NOP_INST     - canonical bubble instruction (addi x0,x0,0)
//   IADR_W_DEF   - default instruction RAM word-address width
//   fetch_pair_t - {inst[31:0], word pc[31:2]} passed from IF to ID
package rv32i_pkg;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          IADR_W_DEF = 12;
    typedef struct packed {
        logic [31:0] inst;
        logic [29:0] pc;
    } fetch_pair_t;
endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: single-entry capture/release register for stalled return data.
//   clk, rst - clock, synchronous active-high reset
//   load     - capture din (sets vld)
//   rel      - entry consumed downstream (clears vld)
//   clr      - discard the entry; beats load and rel
//   din      - data to capture
//   vld      - entry holds valid data
//   dout     - captured data
module if_hold_buf #(
    parameter int W = 62
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         rel,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         vld,
    output logic [W-1:0] dout
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld <= 1'b0;
        end else if (load) begin
            vld  <= 1'b1;
            dout <= din;
        end else if (rel) begin
            vld <= 1'b0;
        end
    end

    // A second capture while the entry is still occupied would lose data.
    overflow_a: assert property (@(posedge clk) disable iff (rst) !(load && vld && !rel && !clr));
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch between the PC stage and ID, 1-cycle sync RAM.
//   clk, rst     - clock, synchronous active-high reset
//   pc           - word PC [31:2]; cpu_stat_pc marks a fetch request
//   stall        - ID cannot accept; output held
//   flush        - kill every in-flight fetch and the held entry
//   imem_radr/re - RAM read port; imem_rdata returns one cycle after re
//   fetch_ready  - a request this cycle will be issued (absent flush)
//   inst_id, pc_id, inst_vld_id - fetched pair delivered to ID
module if_stage #(
    parameter int          IADR_W   = rv32i_pkg::IADR_W_DEF,
    parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [29:0]       pc,
    input  logic              cpu_stat_pc,
    input  logic              stall,
    input  logic              flush,
    output logic [IADR_W-1:0] imem_radr,
    output logic              imem_re,
    input  logic [31:0]       imem_rdata,
    output logic              fetch_ready,
    output logic [31:0]       inst_id,
    output logic [29:0]       pc_id,
    output logic              inst_vld_id
);
    rv32i_pkg::fetch_pair_t ret_pair, hold_pair;
    logic                   req_vld_q, hold_vld;
    logic [29:0]            req_pc_q;

    // Issue is blocked while anything waits in the hold buffer, which is
    // what bounds the buffer to a single entry.
    assign fetch_ready = ~stall & ~hold_vld;
    assign imem_re     = cpu_stat_pc & fetch_ready & ~flush & ~rst;
    assign imem_radr   = pc[IADR_W-1:0];
    assign ret_pair    = '{inst: imem_rdata, pc: req_pc_q};

    if_hold_buf #(.W($bits(rv32i_pkg::fetch_pair_t))) u_hold (
        .clk  (clk),
        .rst  (rst),
        .load (stall & req_vld_q),
        .rel  (~stall & hold_vld),
        .clr  (flush),
        .din  (ret_pair),
        .vld  (hold_vld),
        .dout (hold_pair)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_vld_q   <= 1'b0;
            req_pc_q    <= '0;
            inst_id     <= NOP_INST;
            pc_id       <= '0;
            inst_vld_id <= 1'b0;
        end else begin
            // imem_re is already low under flush, so this also drops the request.
            req_vld_q <= imem_re;
            if (imem_re)
                req_pc_q <= pc;
            if (flush) begin
                inst_id     <= NOP_INST;
                inst_vld_id <= 1'b0;
            end else if (!stall) begin
                if (hold_vld) begin
                    inst_id     <= hold_pair.inst;
                    pc_id       <= hold_pair.pc;
                    inst_vld_id <= 1'b1;
                end else if (req_vld_q) begin
                    inst_id     <= imem_rdata;
                    pc_id       <= req_pc_q;
                    inst_vld_id <= 1'b1;
                end else begin
                    inst_id     <= NOP_INST;
                    inst_vld_id <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven directed check of if_stage against a 1-cycle RAM.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, cps, stall, flush;
    logic [29:0] pc;
    logic [11:0] imem_radr;
    logic        imem_re, fetch_ready, inst_vld_id;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst_id;
    logic [29:0] pc_id;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .cpu_stat_pc (cps),
        .stall       (stall),
        .flush       (flush),
        .imem_radr   (imem_radr),
        .imem_re     (imem_re),
        .imem_rdata  (imem_rdata),
        .fetch_ready (fetch_ready),
        .inst_id     (inst_id),
        .pc_id       (pc_id),
        .inst_vld_id (inst_vld_id)
    );

    always #5 clk = ~clk;

    // RAM contents: word k holds k*0x11.
    always_ff @(posedge clk)
        if (imem_re)
            imem_rdata <= {20'h0, imem_radr} * 32'h11;

    typedef struct {
        logic        r, c, s, f;
        logic [29:0] p;
        logic        rdy, re, vld;
        logic [31:0] inst;
        logic [29:0] pcid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic c, logic s, logic f, logic [29:0] p,
                                logic rdy, logic re, logic vld, logic [31:0] inst, logic [29:0] pcid);
        vec_t v;
        v.r = r; v.c = c; v.s = s; v.f = f; v.p = p;
        v.rdy = rdy; v.re = re; v.vld = vld; v.inst = inst; v.pcid = pcid;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        //            r  c  s  f  pc            rdy re vld inst      pc_id
        // back-to-back stream
        tbl.push_back(mk(0, 1, 0, 0, 30'h100,      1, 1, 0, NOP,      30'h0));
        tbl.push_back(mk(0, 1, 0, 0, 30'h101,      1, 1, 1, 32'h1100, 30'h100));
        tbl.push_back(mk(0, 1, 0, 0, 30'h102,      1, 1, 1, 32'h1111, 30'h101));
        tbl.push_back(mk(0, 1, 0, 0, 30'h103,      1, 1, 1, 32'h1122, 30'h102));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 1, 32'h1133, 30'h103));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 0, NOP,      30'h103));
        // stall for 3 cycles right after 0x200 issues
        tbl.push_back(mk(0, 1, 0, 0, 30'h1FF,      1, 1, 0, NOP,      30'h103));
        tbl.push_back(mk(0, 1, 0, 0, 30'h200,      1, 1, 1, 32'h21EF, 30'h1FF));
        tbl.push_back(mk(0, 1, 1, 0, 30'h201,      0, 0, 1, 32'h21EF, 30'h1FF));
        tbl.push_back(mk(0, 1, 1, 0, 30'h201,      0, 0, 1, 32'h21EF, 30'h1FF));
        tbl.push_back(mk(0, 1, 1, 0, 30'h201,      0, 0, 1, 32'h21EF, 30'h1FF));
        tbl.push_back(mk(0, 1, 0, 0, 30'h201,      0, 0, 1, 32'h2200, 30'h200));
        tbl.push_back(mk(0, 1, 0, 0, 30'h201,      1, 1, 0, NOP,      30'h200));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 1, 32'h2211, 30'h201));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 0, NOP,      30'h201));
        // flush the cycle after 0x300 issues, with a competing request
        tbl.push_back(mk(0, 1, 0, 0, 30'h300,      1, 1, 0, NOP,      30'h201));
        tbl.push_back(mk(0, 1, 0, 1, 30'h301,      1, 0, 0, NOP,      30'h201));
        tbl.push_back(mk(0, 1, 0, 0, 30'h040,      1, 1, 0, NOP,      30'h201));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 1, 32'h0440, 30'h040));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 0, NOP,      30'h040));
        // flush + stall while the hold buffer is occupied
        tbl.push_back(mk(0, 1, 0, 0, 30'h050,      1, 1, 0, NOP,      30'h040));
        tbl.push_back(mk(0, 1, 0, 0, 30'h051,      1, 1, 1, 32'h0550, 30'h050));
        tbl.push_back(mk(0, 1, 1, 0, 30'h052,      0, 0, 1, 32'h0550, 30'h050));
        tbl.push_back(mk(0, 1, 1, 1, 30'h052,      0, 0, 0, NOP,      30'h050));
        tbl.push_back(mk(0, 1, 0, 0, 30'h060,      1, 1, 0, NOP,      30'h050));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 1, 32'h0660, 30'h060));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 0, NOP,      30'h060));
        // full PC retained while the RAM address wraps
        tbl.push_back(mk(0, 1, 0, 0, 30'h3FFFFFFF, 1, 1, 0, NOP,      30'h060));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 1, 32'h10FEF, 30'h3FFFFFFF));
        // reset with a fetch in flight; stale data must never surface
        tbl.push_back(mk(0, 1, 0, 0, 30'h123,      1, 1, 0, NOP,      30'h3FFFFFFF));
        tbl.push_back(mk(1, 1, 0, 0, 30'h124,      1, 0, 0, NOP,      30'h0));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 0, NOP,      30'h0));
        tbl.push_back(mk(0, 1, 0, 0, 30'h105,      1, 1, 0, NOP,      30'h0));
        tbl.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 1, 32'h1155, 30'h105));

        rst = 1'b1; cps = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset vld",   {63'h0, inst_vld_id}, 64'h0);
        chk("reset inst",  {32'h0, inst_id},     {32'h0, NOP});
        chk("reset pc",    {34'h0, pc_id},       64'h0);
        chk("reset ready", {63'h0, fetch_ready}, 64'h1);
        chk("reset re",    {63'h0, imem_re},     64'h0);

        foreach (tbl[i]) begin
            rst = tbl[i].r; cps = tbl[i].c; stall = tbl[i].s; flush = tbl[i].f; pc = tbl[i].p;
            #1;
            chk($sformatf("row%0d ready", i), {63'h0, fetch_ready}, {63'h0, tbl[i].rdy});
            chk($sformatf("row%0d re", i),    {63'h0, imem_re},     {63'h0, tbl[i].re});
            if (tbl[i].re)
                chk($sformatf("row%0d radr", i), {52'h0, imem_radr}, {52'h0, tbl[i].p[11:0]});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d vld", i),  {63'h0, inst_vld_id}, {63'h0, tbl[i].vld});
            chk($sformatf("row%0d inst", i), {32'h0, inst_id},     {32'h0, tbl[i].inst});
            chk($sformatf("row%0d pc", i),   {34'h0, pc_id},       {34'h0, tbl[i].pcid});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage. Sits directly downstream of the PC stage and upstream of the decode (ID) stage.
- Consumes the 30-bit word PC and the PC-state strobe, and issues reads to the synchronous instruction RAM (1-cycle read latency).
- Delivers {instruction, pc} pairs to ID with a valid flag, holding them across pipeline stalls.
- Discards wrong-path fetches on jump, exception or return flushes.

Parameters:
- IADR_W, 12: instruction RAM word-address width; the RAM holds 2^IADR_W words.
- NOP_INST, 32'h0000_0013: instruction driven when there is no valid fetch (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pc  in  30  word PC [31:2] from the PC stage
- cpu_stat_pc  in  1  PC stage valid this cycle; a fetch request is presented
- stall  in  1  ID cannot accept; hold the output
- flush  in  1  jump/interrupt/exception/xRET taken in EX; kill all in-flight fetches
- imem_radr  out  IADR_W  instruction RAM read address (= pc[IADR_W+1:2])
- imem_re  out  1  instruction RAM read enable
- imem_rdata  in  32  RAM read data, valid the cycle after imem_re
- fetch_ready  out  1  stage can accept a new request this cycle
- inst_id  out  32  instruction to ID
- pc_id  out  30  word PC [31:2] of inst_id
- inst_vld_id  out  1  inst_id/pc_id valid

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - inst_id=NOP_INST, pc_id=0, inst_vld_id=0
  - in-flight flag=0, hold buffer empty
  - imem_re=0
- Reset mid-fetch discards everything. The first request after reset is accepted no earlier than the cycle after rst deasserts.
- fetch_ready = ~stall & ~hold_vld. Purely combinational.
- Issue:
  - imem_re = cpu_stat_pc & fetch_ready & ~flush.
  - imem_radr is driven combinationally from pc in the same cycle.
  - On issue, register req_vld_q=1 and req_pc_q=pc.
- Return: the cycle after issue, imem_rdata is valid and paired with req_pc_q.
- Output register update each cycle, first match wins:
  1. flush: inst_vld_id<=0, inst_id<=NOP_INST; req_vld_q<=0; hold_vld<=0. The returning datum is dropped. flush beats stall.
  2. stall: the output register keeps its value. If req_vld_q, the returning {imem_rdata, req_pc_q} is captured into the hold buffer (hold_vld<=1).
  3. hold_vld & ~stall: output <= hold buffer, inst_vld_id<=1, hold_vld<=0. No issue this cycle because fetch_ready=0.
  4. req_vld_q: output <= {imem_rdata, req_pc_q}, inst_vld_id<=1.
  5. otherwise: inst_vld_id<=0, inst_id<=NOP_INST; pc_id holds.
- Hold buffer depth 1 suffices: issue is blocked while stall or hold_vld is set, so at most one datum can be in flight when a stall begins. A request arriving while hold_vld=1 is an overflow; this is an assertion failure.
- Throughput: 1 instruction per cycle when unstalled. Latency is 2 clocks from issue (cpu_stat_pc) to inst_vld_id.
- Simultaneous events:
  - flush with cpu_stat_pc: no issue that cycle. The PC stage re-presents the target PC next cycle.
  - flush with hold_vld: the hold buffer is cleared.
- pc bits above IADR_W+1 are ignored; the address wraps modulo the RAM size.

Decomposition:
- Shared package rv32i_pkg:
  - NOP_INST constant
  - IADR_W default
  - fetch-pair struct/typedef {inst[31:0], pc[31:2]}
- One sub-module: if_hold_buf. A 1-entry capture/release register (load, release, clear, vld, data) reused later by the load/store return path.

Test Plan:
- Reset then 4 consecutive requests pc=0x100..0x103 with RAM[k]=k*0x11: inst_vld_id rises 2 cycles after the first request. inst_id=0x1100,0x1111,0x1122,0x1133 back-to-back, pc_id matches.
- stall asserted for 3 cycles in the cycle after pc=0x200 issues: output frozen on the prior instruction, fetch_ready=0. RAM[0x200] appears on inst_id in the first cycle after stall drops, with no duplicate and no loss.
- flush in the cycle after pc=0x300 issues: inst_vld_id=0 and inst_id=0x00000013 next cycle. The next request pc=0x040 yields pc_id=0x040.
- flush and stall together while hold_vld=1: hold cleared and inst_vld_id=0. After release, only post-flush fetches appear.
- rst pulsed while req_vld_q=1: all outputs at reset values next cycle, and the stale RAM data never appears on inst_id.
- pc=0x3FFF_FFFF with IADR_W=12: imem_radr=0xFFF and pc_id=0x3FFF_FFFF (full PC retained).
